m_stage: RTL and testbench
==========================

Name: m_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly downstream of the Execute stage.
- Holds the EX/MEM pipeline register and the synchronous data memory. Handles sw/sh/sb stores and lw/lh/lhu/lb/lbu loads with extension.
- Produces the MEM/WB register contents for the Write-back stage.
- Exports ALUOutM and PC_M as the forwarding sources that Execute consumes.

Parameters:
- DM_WORDS, 1024, data memory depth in 32-bit words (power of two).
- DM_AW, 10, word-address width; equals log2(DM_WORDS).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- ALU_out_in_M  in  32  ALU result from Execute; memory byte address for loads/stores.
- Data_to_dm_in_M  in  32  forwarded rt value from Execute; store data.
- WriteReg_in_M  in  5  destination register from Execute.
- Instr_in_M  in  32  instruction from Execute.
- PC4_in_M  in  32  PC+4 from Execute.
- movz_rt_zero_in_M  in  1  movz condition from Execute (1 = rt equals zero).
- ALUOutM  out  32  EX/MEM-registered ALU result; forwarding source.
- PC_M  out  32  EX/MEM-registered PC+4; Execute adds 4 for the link value.
- WriteReg_M  out  5  EX/MEM-registered destination, used by the hazard unit.
- Instr_M  out  32  EX/MEM-registered instruction.
- ReadData_W  out  32  MEM/WB load data, already extended.
- ALUOut_W  out  32  MEM/WB ALU result.
- WriteReg_W  out  5  MEM/WB destination.
- Instr_W  out  32  MEM/WB instruction.
- PC4_W  out  32  MEM/WB PC+4.

Behaviour:
- Single clock; all state updates on posedge clk. No stall or flush input: stalls are held upstream in Decode.
- Reset (sync, high): all EX/MEM and MEM/WB registers become 0, and every memory word becomes 0 within that same edge.
  - All outputs read 0 in the cycle after reset.
  - Reset overrides a store presented in the same cycle; that store does not take effect.
- EX/MEM register: on each edge it latches ALU_out_in_M, Data_to_dm_in_M, Instr_in_M, PC4_in_M and the WriteReg.
- MOVZ gating applies when the instruction is MOVZ (opcode 0x00, funct 0x0A) and movz_rt_zero_in_M = 0. In that case 0 is latched as WriteReg, cancelling the write-back.
- Memory address:
  - Word index is ALUOutM[DM_AW+1:2]; byte offset is ALUOutM[1:0].
  - Upper address bits are ignored, so accesses wrap modulo DM_WORDS.
- Stores are performed at the edge that ends the instruction's M cycle, using EX/MEM values.
  - sw (0x2B): whole word written; ALUOutM[1:0] ignored.
  - sh (0x29): halfword data[15:0] written to bytes {1,0} if ALUOutM[1]=0, else to bytes {3,2}.
  - sb (0x28): data[7:0] written to the byte selected by ALUOutM[1:0]. Other bytes unchanged.
- Loads read combinationally from the current memory array and are extended, then latched into ReadData_W at the same edge.
  - lw (0x23): full word.
  - lh (0x21) and lb (0x20): sign-extended.
  - lhu (0x25) and lbu (0x24): zero-extended.
  - Byte and halfword lane selection matches the stores.
  - Non-load instructions: ReadData_W latches 0.
- Load latency: the address is in M during cycle n, and data is valid on ReadData_W in cycle n+1.
- A store immediately followed by a load to the same word: the load (M in cycle n+1) sees the stored value, because the write has committed at the end of cycle n.
- MEM/WB register: latches ALUOutM, WriteReg_M, Instr_M and PC_M into ALUOut_W, WriteReg_W, Instr_W and PC4_W.
- Word-aligned lw/sw with misaligned addresses are not trapped.

Optional Feature:
- Macro: DM_WRITE_LOG_EN.
- When defined: each committed store issues a simulation $display of the form "@<PC4-4 hex>: *<word-aligned addr hex> <= <full resulting 32-bit word hex>". No message is printed under reset.
- When undefined: no display code is compiled. Functional behaviour is identical.

Decomposition:
- Shared package/header (mips_defs): opcode constants (LW, LH, LHU, LB, LBU, SW, SH, SB, SPECIAL) and funct constant MOVZ. Existing decoders reuse the same constants.
- One sub-module, dm_bank:
  - synchronous byte-enabled RAM with 4-bit byte enable and sync reset clear;
  - combinational read port;
  - parameterised by DM_WORDS.
- Byte-enable generation and load extension stay in m_stage.

Test Plan:
- Reset held 1 cycle with a sw in flight -> all outputs 0 next cycle; the target word reads 0 afterwards.
- sw 0x12345678 at addr 0x10, then lw at 0x10 back-to-back -> ReadData_W = 0x12345678 one cycle after the lw's M cycle.
- sb 0xAB at 0x13 onto word 0 in place, then lb 0x13 and lbu 0x13 -> the word reads 0xAB000000; lb gives 0xFFFFFFAB; lbu gives 0x000000AB.
- sh 0x8001 at 0x22, then lh 0x22 / lhu 0x22 / lw 0x20 -> 0xFFFF8001 / 0x00008001 / 0x80010000.
- movz with movz_rt_zero_in_M=0, WriteReg_in_M=5 -> WriteReg_M=0 and WriteReg_W=0; repeat with flag=1 -> 5 on both.
- sw to addr 0x1000 with DM_WORDS=1024 -> wraps to word 0; lw 0x0 returns the stored value. PC_M and PC4_W track PC4_in_M with 1- and 2-cycle delay.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants: opcodes and funct codes used by the
// pipeline stages, plus the load-kind classification used by m_stage.
package mips_defs_pkg;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpLhu     = 6'h25;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2B;

  localparam logic [5:0] FnMovz    = 6'h0A;

  typedef enum logic [2:0] {
    LdNone,
    LdW,
    LdH,
    LdHu,
    LdB,
    LdBu
  } ld_kind_e;

  // Classify an opcode by the kind of load it performs.
  function automatic ld_kind_e ld_kind(logic [5:0] op);
    ld_kind_e k;
    case (op)
      OpLw:    k = LdW;
      OpLh:    k = LdH;
      OpLhu:   k = LdHu;
      OpLb:    k = LdB;
      OpLbu:   k = LdBu;
      default: k = LdNone;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/m_stage_dm_bank.sv
// dm_bank: synchronous byte-enabled data RAM with combinational read and a
// synchronous reset that clears every word in a single edge.
module dm_bank #(
  parameter int unsigned DM_WORDS = 1024,
  parameter int unsigned AW       = $clog2(DM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DM_WORDS];

  // Byte-lane writes; reset wipes the array and masks any write that edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/m_stage.sv
// m_stage: MIPS memory stage. Holds the EX/MEM register, the data memory and
// the MEM/WB register. Stores use byte enables; loads are extended here.
// Optional macro DM_WRITE_LOG_EN prints one line per committed store.
module m_stage
  import mips_defs_pkg::*;
#(
  parameter int unsigned DM_WORDS = 1024,
  parameter int unsigned DM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_out_in_M,
  input  logic [31:0] Data_to_dm_in_M,
  input  logic [4:0]  WriteReg_in_M,
  input  logic [31:0] Instr_in_M,
  input  logic [31:0] PC4_in_M,
  input  logic        movz_rt_zero_in_M,
  output logic [31:0] ALUOutM,
  output logic [31:0] PC_M,
  output logic [4:0]  WriteReg_M,
  output logic [31:0] Instr_M,
  output logic [31:0] ReadData_W,
  output logic [31:0] ALUOut_W,
  output logic [4:0]  WriteReg_W,
  output logic [31:0] Instr_W,
  output logic [31:0] PC4_W
);

  // EX/MEM
  logic [31:0] r_alu, r_data, r_instr, r_pc4;
  logic [4:0]  r_wreg;
  // MEM/WB
  logic [31:0] r_rd_w, r_alu_w, r_instr_w, r_pc4_w;
  logic [4:0]  r_wreg_w;

  logic [4:0]       w_wreg_in;
  logic [5:0]       w_op;
  logic [1:0]       w_off;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rword;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ld_data;
  logic [DM_AW-1:0] w_waddr;

  assign w_op    = r_instr[31:26];
  assign w_off   = r_alu[1:0];
  assign w_waddr = r_alu[DM_AW+1:2];

  // A MOVZ whose rt is non-zero must not write back: cancel via register 0
  always_comb begin
    w_wreg_in = WriteReg_in_M;
    if (Instr_in_M[31:26] == OpSpecial && Instr_in_M[5:0] == FnMovz && !movz_rt_zero_in_M) begin
      w_wreg_in = 5'd0;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu   <= '0;
      r_data  <= '0;
      r_instr <= '0;
      r_pc4   <= '0;
      r_wreg  <= '0;
    end else begin
      r_alu   <= ALU_out_in_M;
      r_data  <= Data_to_dm_in_M;
      r_instr <= Instr_in_M;
      r_pc4   <= PC4_in_M;
      r_wreg  <= w_wreg_in;
    end
  end

  // Store byte enables; store data is replicated so each lane sees its bytes
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = r_data;
    case (w_op)
      OpSw: begin
        w_be    = 4'b1111;
        w_wdata = r_data;
      end
      OpSh: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {r_data[15:0], r_data[15:0]};
      end
      OpSb: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{r_data[7:0]}};
      end
      default: ;
    endcase
  end

  dm_bank #(
    .DM_WORDS (DM_WORDS),
    .AW       (DM_AW)
  ) u_dm_bank (
    .clk     (clk),
    .reset   (reset),
    .i_be    (w_be),
    .i_addr  (w_waddr),
    .i_wdata (w_wdata),
    .o_rdata (w_rword)
  );

  // Lane select and extension for loads
  always_comb begin
    w_byte    = w_rword[8*w_off +: 8];
    w_half    = w_off[1] ? w_rword[31:16] : w_rword[15:0];
    w_ld_data = '0;
    case (ld_kind(w_op))
      LdW:     w_ld_data = w_rword;
      LdH:     w_ld_data = {{16{w_half[15]}}, w_half};
      LdHu:    w_ld_data = {16'h0000, w_half};
      LdB:     w_ld_data = {{24{w_byte[7]}}, w_byte};
      LdBu:    w_ld_data = {24'h000000, w_byte};
      default: w_ld_data = '0;
    endcase
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_w    <= '0;
      r_alu_w   <= '0;
      r_instr_w <= '0;
      r_pc4_w   <= '0;
      r_wreg_w  <= '0;
    end else begin
      r_rd_w    <= w_ld_data;
      r_alu_w   <= r_alu;
      r_instr_w <= r_instr;
      r_pc4_w   <= r_pc4;
      r_wreg_w  <= r_wreg;
    end
  end

`ifdef DM_WRITE_LOG_EN
  logic [31:0] w_merged;

  // Word as it will read after this store commits
  always_comb begin
    w_merged = w_rword;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) w_merged[8*b +: 8] = w_wdata[8*b +: 8];
    end
  end

  // Log committed stores only
  always_ff @(posedge clk) begin
    if (!reset && (w_be != 4'b0000)) begin
      $display("@%08h: *%08h <= %08h", r_pc4 - 32'd4, {r_alu[31:2], 2'b00}, w_merged);
    end
  end
`endif

  assign ALUOutM    = r_alu;
  assign PC_M       = r_pc4;
  assign WriteReg_M = r_wreg;
  assign Instr_M    = r_instr;
  assign ReadData_W = r_rd_w;
  assign ALUOut_W   = r_alu_w;
  assign WriteReg_W = r_wreg_w;
  assign Instr_W    = r_instr_w;
  assign PC4_W      = r_pc4_w;

endmodule

// File: tb/tb_m_stage.sv
// Scoreboard bench for m_stage: stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_m_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_in, data_in, instr_in, pc4_in;
  logic [4:0]  wreg_in;
  logic        mz_in;
  logic [31:0] alu_m, pc_m, instr_m, rd_w, alu_w, instr_w, pc4_w;
  logic [4:0]  wreg_m, wreg_w;

  always #5 clk = ~clk;

  m_stage #(
    .DM_WORDS (1024),
    .DM_AW    (10)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ALU_out_in_M      (alu_in),
    .Data_to_dm_in_M   (data_in),
    .WriteReg_in_M     (wreg_in),
    .Instr_in_M        (instr_in),
    .PC4_in_M          (pc4_in),
    .movz_rt_zero_in_M (mz_in),
    .ALUOutM           (alu_m),
    .PC_M              (pc_m),
    .WriteReg_M        (wreg_m),
    .Instr_M           (instr_m),
    .ReadData_W        (rd_w),
    .ALUOut_W          (alu_w),
    .WriteReg_W        (wreg_w),
    .Instr_W           (instr_w),
    .PC4_W             (pc4_w)
  );

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc = 32'h0040_0004;
  string       names [9] = '{"ALUOutM", "PC_M", "WriteReg_M", "Instr_M", "ReadData_W",
                             "ALUOut_W", "WriteReg_W", "Instr_W", "PC4_W"};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] dut_val(int sel);
    case (sel)
      0:       return alu_m;
      1:       return pc_m;
      2:       return {27'd0, wreg_m};
      3:       return instr_m;
      4:       return rd_w;
      5:       return alu_w;
      6:       return {27'd0, wreg_w};
      7:       return instr_w;
      default: return pc4_w;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] got;
      e   = sb.pop_front();
      got = dut_val(e.sel);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s cyc %0d: got %08h expected %08h", names[e.sel], cyc, got, e.exp);
      end
    end
  end

  function automatic logic [31:0] itype(logic [5:0] op);
    return {op, 5'd4, 5'd5, 16'h0010};
  endfunction

  function automatic logic [31:0] rtype(logic [5:0] fn);
    return {6'h00, 5'd4, 5'd5, 5'd5, 5'd0, fn};
  endfunction

  task automatic push(int unsigned c, int sel, logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Present one instruction for a cycle; M outputs due next cycle, W the one after
  task automatic issue(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] wreg, input logic mz, input logic [31:0] exp_rd,
                       input logic [4:0] exp_wr, input bit chk_w);
    int unsigned c;
    c        = cyc;
    reset    = 1'b0;
    instr_in = instr;
    alu_in   = addr;
    data_in  = data;
    wreg_in  = wreg;
    mz_in    = mz;
    pc4_in   = pc;
    push(c + 1, 0, addr);
    push(c + 1, 1, pc);
    push(c + 1, 2, {27'd0, exp_wr});
    push(c + 1, 3, instr);
    if (chk_w) begin
      push(c + 2, 4, exp_rd);
      push(c + 2, 5, addr);
      push(c + 2, 6, {27'd0, exp_wr});
      push(c + 2, 7, instr);
      push(c + 2, 8, pc);
    end
    pc = pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  // One reset cycle with junk inputs; every output must read 0 afterwards
  task automatic rst_cycle();
    int unsigned c;
    c        = cyc;
    reset    = 1'b1;
    instr_in = {6'h2B, 26'h0000010};
    alu_in   = 32'h0000_0010;
    data_in  = 32'hFFFF_FFFF;
    wreg_in  = 5'd7;
    mz_in    = 1'b1;
    pc4_in   = 32'h1234_5678;
    for (int s = 0; s < 9; s++) push(c + 1, s, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    instr_in = '0;
    alu_in   = '0;
    data_in  = '0;
    wreg_in  = '0;
    mz_in    = 1'b0;
    pc4_in   = '0;
    @(posedge clk);
    #1;
    rst_cycle();

    // sw in flight when reset hits: must be cancelled
    issue(itype(6'h2B), 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);
    rst_cycle();
    issue(itype(6'h23), 32'h10, 32'h0, 5'd9, 1'b0, 32'h0000_0000, 5'd9, 1'b1);

    // sb onto a cleared word, then readback and byte loads
    issue(itype(6'h28), 32'h13, 32'h1111_11AB, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
    issue(itype(6'h23), 32'h10, 32'h0, 5'd8, 1'b0, 32'hAB00_0000, 5'd8, 1'b1);
    issue(itype(6'h20), 32'h13, 32'h0, 5'd8, 1'b0, 32'hFFFF_FFAB, 5'd8, 1'b1);
    issue(itype(6'h24), 32'h13, 32'h0, 5'd8, 1'b0, 32'h0000_00AB, 5'd8, 1'b1);

    // sw then back-to-back lw; lane checks on the same word
    issue(itype(6'h2B), 32'h10, 32'h1234_5678, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
    issue(itype(6'h23), 32'h10, 32'h0, 5'd2, 1'b0, 32'h1234_5678, 5'd2, 1'b1);
    issue(itype(6'h20), 32'h12, 32'h0, 5'd2, 1'b0, 32'h0000_0034, 5'd2, 1'b1);
    issue(itype(6'h21), 32'h12, 32'h0, 5'd2, 1'b0, 32'h0000_1234, 5'd2, 1'b1);
    issue(itype(6'h24), 32'h11, 32'h0, 5'd2, 1'b0, 32'h0000_0056, 5'd2, 1'b1);

    // sh to upper half, then signed/unsigned/word reads
    issue(itype(6'h29), 32'h22, 32'hFFFF_8001, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
    issue(itype(6'h21), 32'h22, 32'h0, 5'd3, 1'b0, 32'hFFFF_8001, 5'd3, 1'b1);
    issue(itype(6'h25), 32'h22, 32'h0, 5'd3, 1'b0, 32'h0000_8001, 5'd3, 1'b1);
    issue(itype(6'h23), 32'h20, 32'h0, 5'd3, 1'b0, 32'h8001_0000, 5'd3, 1'b1);
    issue(itype(6'h29), 32'h20, 32'h0000_7FFE, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
    issue(itype(6'h23), 32'h20, 32'h0, 5'd3, 1'b0, 32'h8001_7FFE, 5'd3, 1'b1);
    issue(itype(6'h21), 32'h20, 32'h0, 5'd3, 1'b0, 32'h0000_7FFE, 5'd3, 1'b1);

    // movz gating, and a non-movz R-type that must keep its destination
    issue(rtype(6'h0A), 32'h0, 32'h0, 5'd5, 1'b0, 32'h0, 5'd0, 1'b1);
    issue(rtype(6'h0A), 32'h0, 32'h0, 5'd5, 1'b1, 32'h0, 5'd5, 1'b1);
    issue(rtype(6'h21), 32'h77, 32'h0, 5'd3, 1'b0, 32'h0, 5'd3, 1'b1);

    // Address wrap modulo DM_WORDS
    issue(itype(6'h2B), 32'h1000, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
    issue(itype(6'h23), 32'h0, 32'h0, 5'd6, 1'b0, 32'hCAFE_F00D, 5'd6, 1'b1);
    issue(itype(6'h28), 32'h1001, 32'hFFFF_FF55, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
    issue(itype(6'h23), 32'h2000, 32'h0, 5'd6, 1'b0, 32'hCAFE_550D, 5'd6, 1'b1);

    instr_in = '0;
    alu_in   = '0;
    data_in  = '0;
    wreg_in  = '0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
